// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the fetch queue.
//   fetch_entry_t    - one queue entry, {pc, instr}
//   FQ_DEPTH         - default queue depth (power of two, >= 4)
//   FQ_RESET_PC      - default first fetch address after reset
package fetch_pkg;
    localparam int          FQ_DEPTH    = 8;
    localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register and next-PC mux (stall / +4 / +8 / redirect).
//   clk, rst_n      - clock, asynchronous active-low reset (loads RESET_PC)
//   i_redirect      - load word-aligned i_redirect_pc
//   i_redirect_pc   - redirect target, low two bits dropped
//   i_push_cnt      - entries pushed this cycle (0 stall, 1 -> +4, 2 -> +8)
//   o_pc            - current fetch PC
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic [1:0]  i_push_cnt,
    output logic [31:0] o_pc
);
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;

    // Advance by one word per pushed entry; wraps naturally modulo 2^32.
    assign w_pc_next = i_redirect ? (i_redirect_pc & 32'hFFFF_FFFC)
                                  : r_pc + {28'd0, i_push_cnt, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pc <= RESET_PC;
        else        r_pc <= w_pc_next;
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: two-wide instruction fetch into a circular {pc, instr} queue.
//   clk, rst_n           - clock, asynchronous active-low reset
//   A1, A2               - fetch addresses (fetch_pc, fetch_pc+4) to instr_mem
//   RD1, RD2             - instructions returned combinationally for A1/A2
//   redirect_i/_pc_i     - flush queue and restart fetch at the new target
//   pop_i                - instructions consumed by decode (3 treated as 2)
//   valid_o              - bit0 head valid, bit1 head+1 valid
//   instr0/1_o, pc0/1_o  - head and head+1 entries
//   count_o              - current occupancy
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = FQ_DEPTH,
    parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [31:0]                A1,
    output logic [31:0]                A2,
    input  logic [31:0]                RD1,
    input  logic [31:0]                RD2,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    input  logic [1:0]                 pop_i,
    output logic [1:0]                 valid_o,
    output logic [31:0]                instr0_o,
    output logic [31:0]                instr1_o,
    output logic [31:0]                pc0_o,
    output logic [31:0]                pc1_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   r_mem [DEPTH];
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;

    logic [31:0]    w_pc;
    logic [1:0]     w_pop_req;
    logic [CW-1:0]  w_pop_eff;
    logic [CW-1:0]  w_free;
    logic [1:0]     w_push;
    logic [AW-1:0]  w_head1;
    logic [AW-1:0]  w_tail1;

    assign w_pop_req = pop_i[1] ? 2'd2 : pop_i;
    assign w_pop_eff = (CW'(w_pop_req) > r_count) ? r_count : CW'(w_pop_req);
    // Slots freed by this cycle's pop are reusable by this cycle's push.
    assign w_free    = CW'(DEPTH) - r_count + w_pop_eff;
    // An odd-word PC fetches only slot 0 so the next fetch is 8-byte aligned.
    assign w_push    = redirect_i                          ? 2'd0 :
                       (!w_pc[2] && w_free >= CW'(2))      ? 2'd2 :
                       ( w_pc[2] && w_free >= CW'(1))      ? 2'd1 : 2'd0;
    assign w_head1   = r_head + AW'(1);
    assign w_tail1   = r_tail + AW'(1);

    fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_redirect    (redirect_i),
        .i_redirect_pc (redirect_pc_i),
        .i_push_cnt    (w_push),
        .o_pc          (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (redirect_i) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_count <= r_count + CW'(w_push) - w_pop_eff;
            r_head  <= r_head + AW'(w_pop_eff);
            r_tail  <= r_tail + AW'(w_push);
        end
    end

    // Storage is intentionally unreset; validity comes from r_count alone.
    always_ff @(posedge clk) begin
        if (w_push != 2'd0) r_mem[r_tail]  <= '{pc: w_pc,         instr: RD1};
        if (w_push == 2'd2) r_mem[w_tail1] <= '{pc: w_pc + 32'd4, instr: RD2};
    end

    assign A1       = w_pc;
    assign A2       = w_pc + 32'd4;
    assign valid_o  = {r_count >= CW'(2), r_count != '0};
    assign instr0_o = r_mem[r_head].instr;
    assign pc0_o    = r_mem[r_head].pc;
    assign instr1_o = r_mem[w_head1].instr;
    assign pc1_o    = r_mem[w_head1].pc;
    assign count_o  = r_count;
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries (power of two, >=4).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port A1  output  32  fetch address slot 0 to instr_mem, equal to fetch_pc.
REQ-006 SHALL have port A2  output  32  fetch address slot 1, equal to fetch_pc+4.
REQ-007 SHALL have port RD1  input  32  instruction at A1, combinational same cycle.
REQ-008 SHALL have port RD2  input  32  instruction at A2, combinational same cycle.
REQ-009 SHALL have port redirect_i  input  1  branch/jump flush request.
REQ-010 SHALL have port redirect_pc_i  input  32  new fetch target; bits [1:0] ignored.
REQ-011 SHALL have port pop_i  input  2  instructions consumed by decode this cycle (0,1,2; 3 treated as 2).
REQ-012 SHALL have port valid_o  output  2  bit0: head entry valid; bit1: head+1 valid.
REQ-013 SHALL have ports instr0_o, instr1_o  output  32 each  head and head+1 instructions.
REQ-014 SHALL have ports pc0_o, pc1_o  output  32 each  PCs of head and head+1.
REQ-015 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL store {pc, instr} per entry in circular buffer; head/tail pointers wrap modulo DEPTH.
REQ-017 SHALL drive valid_o[0]=(count>=1), valid_o[1]=(count>=2); outputs read from registered entries, no RD-to-output bypass.
REQ-018 SHALL compute effective pop = min(pop_i, count); excess pop ignored, head advances by effective pop.
REQ-019 SHALL compute free = DEPTH - count + effective pop.
REQ-020 SHALL, when fetch_pc[2]=0 and free>=2, push {fetch_pc,RD1} then {fetch_pc+4,RD2}; fetch_pc += 8.
REQ-021 SHALL, when fetch_pc[2]=1 (odd-word target), push only {fetch_pc,RD1} if free>=1; fetch_pc += 4 (realigns).
REQ-022 SHALL otherwise push nothing and hold fetch_pc (stall; A1/A2 stable).
REQ-023 SHALL allow push and pop in same cycle; count_next = count + pushed - effective pop; never exceeds DEPTH, never negative.
REQ-024 SHALL, on redirect_i=1, clear occupancy, reset head=tail=0, set fetch_pc={redirect_pc_i[31:2],2'b00}, ignore pop_i and RD1/RD2 that cycle.
REQ-025 SHALL latency: instruction fetched in cycle N visible on outputs in cycle N+1 at earliest.
REQ-026 SHALL fetch_pc arithmetic wraps modulo 2^32 with no error.

Reset
REQ-027 SHALL on rst_n=0, asynchronously: count=0, head=tail=0, fetch_pc=RESET_PC, valid_o=2'b00.
REQ-028 SHALL keep entry storage unreset; instr/pc outputs are don't-care while invalid.
REQ-029 SHALL discard all in-flight state if reset asserts mid-operation; first push after release uses RESET_PC.

Structure
REQ-030 SHALL place fetch_entry_t {pc, instr}, default DEPTH and RESET_PC in shared package fetch_pkg.
REQ-031 SHALL isolate fetch_pc register and next-PC mux (stall/+4/+8/redirect) in sub-module fetch_pc_gen.
REQ-032 SHALL target 120-400 RTL lines; storage as flop array, no memory macro.

Verification
REQ-033 SHALL reset, RESET_PC=0, pop_i=0, 4 cycles -> count_o 0,2,4,6,8 then holds 8; A1 stalls at 32'h20.
REQ-034 SHALL full queue, pop_i=2 -> same cycle free=2, pushes 2, count_o stays 8, head PC advances by 8.
REQ-035 SHALL redirect_pc_i=32'h104 while count=5 -> next cycle count_o=0, A1=32'h104; following cycle pushes one entry (pc 0x104), A1=32'h108.
REQ-036 SHALL count=1, pop_i=2 -> effective pop 1, no underflow; valid_o=2'b00 if no push that cycle.
REQ-037 SHALL redirect_i and pop_i=2 asserted together with count=4 -> count_o=0, pop ignored.
REQ-038 SHALL assert rst_n low mid-stream with count=6 -> count_o=0 and valid_o=0 immediately, A1=RESET_PC before next clock edge.
